// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: hardwired control unit that walks one instruction through
// fetch (T0..T2) and execute (T3..T6). It drives one-hot register strobes,
// datapath strobes and a one-hot ALU op select. All outputs are registered
// and are decoded from the state being entered, so they reflect the
// registered state only (Moore).
module alu_op_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int MEM_WAIT = 1
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic [31:0]         ir,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic [2:0]          step,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                HIin,
  output logic                LOin,
  output logic [12:0]         alu_sel
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_T0 = 3'd1, S_T1 = 3'd2, S_T2 = 3'd3,
    S_T3   = 3'd4, S_T4 = 3'd5, S_T5 = 3'd6, S_T6 = 3'd7
  } state_t;

  // Instruction class; zero encoding is "illegal" so reset leaves no valid op.
  typedef enum logic [1:0] {
    C_ILL = 2'd0, C_BIN = 2'd1, C_UNA = 2'd2, C_WIDE = 2'd3
  } cls_t;

  // Strobe vector bit positions.
  localparam int B_PCOUT  = 13;
  localparam int B_MARIN  = 12;
  localparam int B_INCPC  = 11;
  localparam int B_ZIN    = 10;
  localparam int B_ZLO    = 9;
  localparam int B_ZHI    = 8;
  localparam int B_PCIN   = 7;
  localparam int B_READ   = 6;
  localparam int B_MDRIN  = 5;
  localparam int B_MDROUT = 4;
  localparam int B_IRIN   = 3;
  localparam int B_YIN    = 2;
  localparam int B_HIIN   = 1;
  localparam int B_LOIN   = 0;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);
  localparam logic [4:0] NREGS5    = 5'(NUM_REGS);

  state_t      state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  cls_t        cls_q, cls_d;
  logic [3:0]  ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic [3:0]  op_q, op_d;

  // Decoder outputs (combinational view of ir).
  cls_t        dec_cls;
  logic [3:0]  dec_op;
  logic [4:0]  opcode;
  logic [3:0]  f_ra, f_rb, f_rc;

  // Output next-state values and their registers.
  logic        busy_d, done_d, ill_d;
  logic        busy_q, done_q, ill_q;
  logic [2:0]  step_d, step_q;
  logic [13:0] strb_d, strb_q;
  logic        rin_en, rout_en, alu_en;
  logic [3:0]  rin_idx, rout_idx;
  logic [NUM_REGS-1:0] rin_d, rout_d, rin_q, rout_q;
  logic [12:0] alu_d, alu_q;

  // Low instruction bits carry no meaning for this control unit.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[14:0];

  assign opcode = ir[31:27];
  assign f_ra   = ir[26:23];
  assign f_rb   = ir[22:19];
  assign f_rc   = ir[18:15];

  // Classify the opcode and reject register fields beyond the register file.
  always_comb begin
    dec_cls = C_ILL;
    dec_op  = 4'd0;
    case (opcode)
      5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
      5'b00101, 5'b00110, 5'b00111, 5'b01000: begin
        dec_cls = C_BIN;
        dec_op  = opcode[3:0];
      end
      5'b01111: begin dec_cls = C_WIDE; dec_op = 4'd9;  end
      5'b10000: begin dec_cls = C_WIDE; dec_op = 4'd10; end
      5'b10001: begin dec_cls = C_UNA;  dec_op = 4'd11; end
      5'b10010: begin dec_cls = C_UNA;  dec_op = 4'd12; end
      default:  begin dec_cls = C_ILL;  dec_op = 4'd0;  end
    endcase
    if ({1'b0, f_ra} >= NREGS5 || {1'b0, f_rb} >= NREGS5) begin
      dec_cls = C_ILL;
    end
    if (dec_cls == C_BIN && {1'b0, f_rc} >= NREGS5) begin
      dec_cls = C_ILL;
    end
  end

  // Next state, T1 wait counter and decode latch (captured leaving T2).
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cls_d   = cls_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_T0;
      S_T0: begin
        state_d = S_T1;
        wait_d  = 3'd0;
      end
      S_T1: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_T2;
          wait_d  = 3'd0;
        end else begin
          wait_d = 3'(wait_q + 3'd1);
        end
      end
      S_T2: begin
        state_d = S_T3;
        cls_d   = dec_cls;
        ra_d    = f_ra;
        rb_d    = f_rb;
        rc_d    = f_rc;
        op_d    = dec_op;
      end
      S_T3:    state_d = (cls_q == C_ILL) ? S_IDLE : S_T4;
      S_T4:    state_d = (cls_q == C_UNA) ? S_IDLE : S_T5;
      S_T5:    state_d = (cls_q == C_WIDE) ? S_T6 : S_IDLE;
      S_T6:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes for the state being entered, so the registered copy is Moore.
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    done_d   = 1'b0;
    ill_d    = 1'b0;
    step_d   = 3'd0;
    strb_d   = '0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    alu_en   = 1'b0;
    rin_idx  = ra_d;
    rout_idx = rb_d;
    case (state_d)
      S_T0: begin
        step_d = 3'd0;
        strb_d[B_PCOUT] = 1'b1;
        strb_d[B_MARIN] = 1'b1;
        strb_d[B_INCPC] = 1'b1;
        strb_d[B_ZIN]   = 1'b1;
      end
      S_T1: begin
        step_d = 3'd1;
        strb_d[B_READ]  = 1'b1;
        strb_d[B_MDRIN] = 1'b1;
        if (wait_d == 3'd0) begin
          strb_d[B_ZLO]  = 1'b1;
          strb_d[B_PCIN] = 1'b1;
        end
      end
      S_T2: begin
        step_d = 3'd2;
        strb_d[B_MDROUT] = 1'b1;
        strb_d[B_IRIN]   = 1'b1;
      end
      S_T3: begin
        step_d = 3'd3;
        case (cls_d)
          C_BIN: begin
            rout_en = 1'b1;
            strb_d[B_YIN] = 1'b1;
          end
          C_UNA: begin
            rout_en = 1'b1;
            alu_en  = 1'b1;
            strb_d[B_ZIN] = 1'b1;
          end
          C_WIDE: begin
            rout_en  = 1'b1;
            rout_idx = ra_d;
            strb_d[B_YIN] = 1'b1;
          end
          default: ill_d = 1'b1;
        endcase
      end
      S_T4: begin
        step_d = 3'd4;
        case (cls_d)
          C_BIN: begin
            rout_en  = 1'b1;
            rout_idx = rc_d;
            alu_en   = 1'b1;
            strb_d[B_ZIN] = 1'b1;
          end
          C_UNA: begin
            rin_en = 1'b1;
            done_d = 1'b1;
            strb_d[B_ZLO] = 1'b1;
          end
          C_WIDE: begin
            rout_en = 1'b1;
            alu_en  = 1'b1;
            strb_d[B_ZIN] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        step_d = 3'd5;
        strb_d[B_ZLO] = 1'b1;
        if (cls_d == C_WIDE) begin
          strb_d[B_LOIN] = 1'b1;
        end else begin
          rin_en = 1'b1;
          done_d = 1'b1;
        end
      end
      S_T6: begin
        step_d = 3'd6;
        done_d = 1'b1;
        strb_d[B_ZHI]  = 1'b1;
        strb_d[B_HIIN] = 1'b1;
      end
      default: ;
    endcase
  end

  // One-hot expansion of register indices and ALU op.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_regsel
      assign rin_d[gi]  = rin_en  && (rin_idx  == 4'(gi));
      assign rout_d[gi] = rout_en && (rout_idx == 4'(gi));
    end
    for (gi = 0; gi < 13; gi++) begin : g_alusel
      assign alu_d[gi] = alu_en && (op_d == 4'(gi));
    end
  endgenerate

  // State, decode and output registers; clear wins over everything.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      wait_q  <= 3'd0;
      cls_q   <= C_ILL;
      ra_q    <= 4'd0;
      rb_q    <= 4'd0;
      rc_q    <= 4'd0;
      op_q    <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
      step_q  <= 3'd0;
      strb_q  <= '0;
      rin_q   <= '0;
      rout_q  <= '0;
      alu_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cls_q   <= cls_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
      step_q  <= step_d;
      strb_q  <= strb_d;
      rin_q   <= rin_d;
      rout_q  <= rout_d;
      alu_q   <= alu_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign illegal  = ill_q;
  assign step     = step_q;
  assign reg_in   = rin_q;
  assign reg_out  = rout_q;
  assign alu_sel  = alu_q;
  assign PCout    = strb_q[B_PCOUT];
  assign MARin    = strb_q[B_MARIN];
  assign IncPC    = strb_q[B_INCPC];
  assign Zin      = strb_q[B_ZIN];
  assign Zlowout  = strb_q[B_ZLO];
  assign Zhighout = strb_q[B_ZHI];
  assign PCin     = strb_q[B_PCIN];
  assign Read     = strb_q[B_READ];
  assign MDRin    = strb_q[B_MDRIN];
  assign MDRout   = strb_q[B_MDROUT];
  assign IRin     = strb_q[B_IRIN];
  assign Yin      = strb_q[B_YIN];
  assign HIin     = strb_q[B_HIIN];
  assign LOin     = strb_q[B_LOIN];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: three instances (16 regs/wait 1,
// 16 regs/wait 4, 8 regs/wait 1) checked cycle by cycle against
// hand-written expected output snapshots.
module tb_alu_op_sequencer;

  localparam logic [13:0] PCOUT  = 14'h2000, MARIN = 14'h1000, INCPC = 14'h0800;
  localparam logic [13:0] ZIN    = 14'h0400, ZLO   = 14'h0200, ZHI   = 14'h0100;
  localparam logic [13:0] PCIN   = 14'h0080, READ  = 14'h0040, MDRIN = 14'h0020;
  localparam logic [13:0] MDROUT = 14'h0010, IRIN  = 14'h0008, YIN   = 14'h0004;
  localparam logic [13:0] HIIN   = 14'h0002, LOIN  = 14'h0001;
  localparam logic [13:0] T0S = PCOUT | MARIN | INCPC | ZIN;
  localparam logic [13:0] T1F = ZLO | PCIN | READ | MDRIN;
  localparam logic [13:0] T1W = READ | MDRIN;
  localparam logic [13:0] T2S = MDROUT | IRIN;

  localparam logic [31:0] I_NOT  = 32'h92380000;
  localparam logic [31:0] I_ADD  = 32'h012B0000;
  localparam logic [31:0] I_MUL  = 32'h79880000;
  localparam logic [31:0] I_NEG  = 32'h8FF80000;
  localparam logic [31:0] I_BAD  = 32'hF8000000;
  localparam logic [31:0] I_RB9  = 32'h92480000;
  localparam logic [31:0] I_JUNK = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic [2:0]  clr_v = 3'b111;
  logic [2:0]  st_v  = 3'b000;
  logic [31:0] ir_v [3];
  logic [65:0] snap [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      localparam int NRG = (gi == 2) ? 8 : 16;
      localparam int MWG = (gi == 1) ? 4 : 1;
      logic busy, done, illegal;
      logic [2:0] step;
      logic [NRG-1:0] rin, rout;
      logic PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin;
      logic Read, MDRin, MDRout, IRin, Yin, HIin, LOin;
      logic [12:0] alu_sel;
      alu_op_sequencer #(.NUM_REGS(NRG), .MEM_WAIT(MWG)) dut (
        .clock(clk), .clear(clr_v[gi]), .start(st_v[gi]), .ir(ir_v[gi]),
        .busy(busy), .done(done), .illegal(illegal), .step(step),
        .reg_in(rin), .reg_out(rout),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .PCin(PCin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin), .alu_sel(alu_sel)
      );
      assign snap[gi] = {step, busy, done, illegal, 16'(rin), 16'(rout),
                         PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin,
                         Read, MDRin, MDRout, IRin, Yin, HIin, LOin, alu_sel};
    end
  endgenerate

  // Expected snapshot; register/ALU index -1 means no bit set.
  function automatic logic [65:0] e(input int stp, input bit bsy, input bit dn,
                                    input bit il, input int ri, input int ro,
                                    input logic [13:0] s, input int al);
    logic [15:0] rim, rom;
    logic [12:0] alm;
    rim = '0; rom = '0; alm = '0;
    if (ri >= 0) rim[ri] = 1'b1;
    if (ro >= 0) rom[ro] = 1'b1;
    if (al >= 0) alm[al] = 1'b1;
    return {3'(stp), bsy, dn, il, rim, rom, s, alm};
  endfunction

  function automatic logic [65:0] idle();
    return e(0, 0, 0, 0, -1, -1, 14'h0, -1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int d, input logic [65:0] exp);
    n_tests++;
    if (snap[d] !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s dut%0d got=%h want=%h", name, d, snap[d], exp);
    end else begin
      $display("[TB] ok   %s dut%0d = %h", name, d, snap[d]);
    end
  endtask

  typedef struct {
    logic        clr;
    logic        st;
    logic [31:0] ir;
    logic [65:0] exp;
    string       name;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic c, input logic s, input logic [31:0] i,
                     input logic [65:0] x, input string n);
    vec_t v;
    v.clr = c; v.st = s; v.ir = i; v.exp = x; v.name = n;
    vq.push_back(v);
  endtask

  initial begin
    ir_v[0] = '0; ir_v[1] = '0; ir_v[2] = '0;

    // Main vector table for instance 0 (16 regs, MEM_WAIT=1).
    add(1, 0, 0,     idle(), "reset");
    add(1, 1, 0,     idle(), "clear_over_start");
    add(0, 0, I_NOT, idle(), "idle_hold");
    add(0, 1, I_NOT, e(0,1,0,0,-1,-1,T0S,-1),  "not_t0");
    add(0, 0, I_NOT, e(1,1,0,0,-1,-1,T1F,-1),  "not_t1");
    add(0, 0, I_NOT, e(2,1,0,0,-1,-1,T2S,-1),  "not_t2");
    add(0, 0, I_NOT, e(3,1,0,0,-1,7,ZIN,12),   "not_t3");
    add(0, 0, I_NOT, e(4,1,1,0,4,-1,ZLO,-1),   "not_t4");
    add(0, 0, I_NOT, idle(), "not_end");
    add(0, 1, I_ADD, e(0,1,0,0,-1,-1,T0S,-1),  "add_t0");
    add(0, 0, I_ADD, e(1,1,0,0,-1,-1,T1F,-1),  "add_t1");
    add(0, 0, I_ADD, e(2,1,0,0,-1,-1,T2S,-1),  "add_t2");
    add(0, 0, I_ADD, e(3,1,0,0,-1,5,YIN,-1),   "add_t3");
    add(0, 0, I_JUNK, e(4,1,0,0,-1,6,ZIN,0),   "add_t4_ir_changed");
    add(0, 0, I_JUNK, e(5,1,1,0,2,-1,ZLO,-1),  "add_t5");
    add(0, 1, I_MUL, idle(), "done_start_ignored");
    add(0, 1, I_MUL, e(0,1,0,0,-1,-1,T0S,-1),  "mul_t0");
    add(0, 1, I_MUL, e(1,1,0,0,-1,-1,T1F,-1),  "mul_t1_start_held");
    add(0, 1, I_MUL, e(2,1,0,0,-1,-1,T2S,-1),  "mul_t2");
    add(0, 1, I_MUL, e(3,1,0,0,-1,3,YIN,-1),   "mul_t3");
    add(0, 1, I_MUL, e(4,1,0,0,-1,1,ZIN,9),    "mul_t4");
    add(0, 1, I_MUL, e(5,1,0,0,-1,-1,ZLO|LOIN,-1), "mul_t5");
    add(0, 1, I_MUL, e(6,1,1,0,-1,-1,ZHI|HIIN,-1), "mul_t6");
    add(0, 1, I_MUL, idle(), "mul_end");
    add(0, 1, I_MUL, e(0,1,0,0,-1,-1,T0S,-1),  "mul2_t0");
    add(0, 0, I_MUL, e(1,1,0,0,-1,-1,T1F,-1),  "mul2_t1");
    add(0, 0, I_MUL, e(2,1,0,0,-1,-1,T2S,-1),  "mul2_t2");
    add(0, 0, I_MUL, e(3,1,0,0,-1,3,YIN,-1),   "mul2_t3");
    add(0, 0, I_MUL, e(4,1,0,0,-1,1,ZIN,9),    "mul2_t4");
    add(1, 0, I_MUL, idle(), "clear_in_t4");
    add(0, 0, I_MUL, idle(), "after_clear_1");
    add(0, 0, I_MUL, idle(), "after_clear_2");
    add(0, 1, I_NEG, e(0,1,0,0,-1,-1,T0S,-1),  "neg_t0");
    add(0, 0, I_NEG, e(1,1,0,0,-1,-1,T1F,-1),  "neg_t1");
    add(0, 0, I_NEG, e(2,1,0,0,-1,-1,T2S,-1),  "neg_t2");
    add(0, 0, I_NEG, e(3,1,0,0,-1,15,ZIN,11),  "neg_same_reg_t3");
    add(0, 0, I_NEG, e(4,1,1,0,15,-1,ZLO,-1),  "neg_same_reg_t4");
    add(0, 0, I_NEG, idle(), "neg_end");

    // Instances 1 and 2 sit in reset while the table runs.
    foreach (vq[k]) begin
      clr_v[0] = vq[k].clr;
      st_v[0]  = vq[k].st;
      ir_v[0]  = vq[k].ir;
      tick();
      chk(vq[k].name, 0, vq[k].exp);
    end
    chk("dut1_reset", 1, idle());
    chk("dut2_reset", 2, idle());
    clr_v = 3'b000;
    st_v  = 3'b000;

    // MEM_WAIT=4: four read cycles, PCin only first, then illegal opcode.
    ir_v[1] = I_BAD;
    st_v[1] = 1'b1;
    tick(); chk("w4_t0", 1, e(0,1,0,0,-1,-1,T0S,-1));
    st_v[1] = 1'b0;
    tick(); chk("w4_t1_first", 1, e(1,1,0,0,-1,-1,T1F,-1));
    for (int k = 0; k < 3; k++) begin
      tick(); chk($sformatf("w4_t1_wait%0d", k + 1), 1, e(1,1,0,0,-1,-1,T1W,-1));
    end
    tick(); chk("w4_t2", 1, e(2,1,0,0,-1,-1,T2S,-1));
    tick(); chk("w4_illegal_t3", 1, e(3,1,0,1,-1,-1,14'h0,-1));
    tick(); chk("w4_illegal_end", 1, idle());
    tick(); chk("w4_stays_idle", 1, idle());

    // MEM_WAIT=4: clear in the middle of the T1 wait resets the counter.
    ir_v[1] = I_NOT;
    st_v[1] = 1'b1;
    tick(); chk("w4c_t0", 1, e(0,1,0,0,-1,-1,T0S,-1));
    st_v[1] = 1'b0;
    tick(); chk("w4c_t1_first", 1, e(1,1,0,0,-1,-1,T1F,-1));
    tick(); chk("w4c_t1_wait", 1, e(1,1,0,0,-1,-1,T1W,-1));
    clr_v[1] = 1'b1;
    st_v[1]  = 1'b1;
    tick(); chk("w4c_clear_mid_t1", 1, idle());
    clr_v[1] = 1'b0;
    tick(); chk("w4c_restart_t0", 1, e(0,1,0,0,-1,-1,T0S,-1));
    st_v[1] = 1'b0;
    tick(); chk("w4c_restart_t1_first", 1, e(1,1,0,0,-1,-1,T1F,-1));
    for (int k = 0; k < 3; k++) begin
      tick(); chk($sformatf("w4c_t1_wait%0d", k + 1), 1, e(1,1,0,0,-1,-1,T1W,-1));
    end
    tick(); chk("w4c_t2", 1, e(2,1,0,0,-1,-1,T2S,-1));
    tick(); chk("w4c_not_t3", 1, e(3,1,0,0,-1,7,ZIN,12));
    tick(); chk("w4c_not_t4", 1, e(4,1,1,0,4,-1,ZLO,-1));
    tick(); chk("w4c_end", 1, idle());

    // NUM_REGS=8: R4/R7 legal, Rb=9 rejected.
    ir_v[2] = I_NOT;
    st_v[2] = 1'b1;
    tick(); chk("r8_t0", 2, e(0,1,0,0,-1,-1,T0S,-1));
    st_v[2] = 1'b0;
    tick(); chk("r8_t1", 2, e(1,1,0,0,-1,-1,T1F,-1));
    tick(); chk("r8_t2", 2, e(2,1,0,0,-1,-1,T2S,-1));
    tick(); chk("r8_not_t3", 2, e(3,1,0,0,-1,7,ZIN,12));
    tick(); chk("r8_not_t4", 2, e(4,1,1,0,4,-1,ZLO,-1));
    tick(); chk("r8_not_end", 2, idle());
    ir_v[2] = I_RB9;
    st_v[2] = 1'b1;
    tick(); chk("r8_rb9_t0", 2, e(0,1,0,0,-1,-1,T0S,-1));
    st_v[2] = 1'b0;
    tick(); chk("r8_rb9_t1", 2, e(1,1,0,0,-1,-1,T1F,-1));
    tick(); chk("r8_rb9_t2", 2, e(2,1,0,0,-1,-1,T2S,-1));
    tick(); chk("r8_rb9_illegal", 2, e(3,1,0,1,-1,-1,14'h0,-1));
    tick(); chk("r8_rb9_end", 2, idle());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
